// File: rtl/lanectrl_pause_pkg.sv
// Shared definitions for the lane-controller pause sequencer.
//   - pause_state_e   : sequencer FSM state encoding
//   - pause_cnt_width : width of the shared phase down-counter
//   - DEF_*           : default timing constants
package lanectrl_pause_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_PRE_CYCLES     = 4;
    localparam int DEF_POST_CYCLES    = 4;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_GRANT = 3'd2,
        ST_POST  = 3'd3,
        ST_GAP   = 3'd4
    } pause_state_e;

    // Wide enough to hold the largest reload value of any phase.
    function automatic int pause_cnt_width(input int pre, input int post,
                                           input int gap, input int tmo);
        int m;
        m = pre;
        if (post > m) m = post;
        if (gap > m)  m = gap;
        if (tmo > m)  m = tmo;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lanectrl_pause_rr_arb.sv
// Round-robin requester pick for the pause sequencer.
//   CLK, RESET  : clock, async active-high reset
//   req_i       : requests eligible for arbitration
//   upd_i       : advance pointer past upd_idx_i
//   upd_idx_i   : index of the requester that was just served
//   win_o       : first requesting index at or after the pointer
//   valid_o     : at least one request is present
module lanectrl_pause_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               upd_i,
    input  logic [IW-1:0]      upd_idx_i,
    output logic [IW-1:0]      win_o,
    output logic               valid_o
);

    // Pointer holds the index where the next search begins.
    logic [IW-1:0] ptr_q;

    always_comb begin
        int idx;
        idx     = 0;
        win_o   = '0;
        valid_o = 1'b0;
        // Scan from farthest to nearest so the nearest hit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (req_i[idx[IW-1:0]]) begin
                win_o   = idx[IW-1:0];
                valid_o = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr_q <= '0;
        end else if (upd_i) begin
            ptr_q <= (upd_idx_i == IW'(NUM_REQ - 1)) ? '0 : upd_idx_i + IW'(1);
        end
    end

endmodule

// File: rtl/lanectrl_pause_sequencer.sv
// Pause-window sequencer sharing HS_IO_CLK_PAUSE among several requesters.
// Each window: pause setup (PRE), grant (GRANT), pause hold (POST), gap (GAP).
//   CLK, RESET      : clock, async active-high reset
//   REQ             : level requests, held for the whole window
//   GNT             : one-hot grant, only in GRANT
//   HS_IO_CLK_PAUSE : registered pause to the lane controllers
//   BUSY            : high outside IDLE
//   TIMEOUT_ERR     : one-cycle pulse on a forced GRANT exit
// Build option: define PAUSE_SEQ_TIMEOUT_EN to bound GRANT to TIMEOUT_CYCLES.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no window; arbitrate on any request
// ST_PRE   | pause high, waiting PRE_CYCLES before granting
// ST_GRANT | GNT[winner] and pause high while REQ[winner] stays high
// ST_POST  | grant removed, pause held POST_CYCLES
// ST_GAP   | pause low for GAP_CYCLES before the next window
module lanectrl_pause_sequencer
    import lanectrl_pause_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int PRE_CYCLES     = DEF_PRE_CYCLES,
    parameter int POST_CYCLES    = DEF_POST_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] GNT,
    output logic               HS_IO_CLK_PAUSE,
    output logic               BUSY,
    output logic               TIMEOUT_ERR
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = pause_cnt_width(PRE_CYCLES, POST_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] PRE_LD  = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] POST_LD = CW'(POST_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

    pause_state_e       state_q;
    logic [CW-1:0]      cnt_q;
    logic [IW-1:0]      win_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               pause_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] req_arb;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IW-1:0]      arb_win;
    logic               arb_valid;
    logic               ptr_upd;

`ifdef PAUSE_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT_CYCLES - 1);
    // Requesters that timed out stay invisible to the arbiter until seen low.
    logic [NUM_REQ-1:0] block_q;
    logic               tmo_q;
    assign req_arb     = REQ & ~block_q;
    assign TIMEOUT_ERR = tmo_q;
`else
    assign req_arb     = REQ;
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign win_onehot = NUM_REQ'(1) << win_q;

    // Pointer moves on leaving PRE, whether to GRANT or by abort.
    assign ptr_upd = (state_q == ST_PRE) && (!REQ[win_q] || (cnt_q == '0));

    lanectrl_pause_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_i     (req_arb),
        .upd_i     (ptr_upd),
        .upd_idx_i (win_q),
        .win_o     (arb_win),
        .valid_o   (arb_valid)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            pause_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PAUSE_SEQ_TIMEOUT_EN
            block_q <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
`ifdef PAUSE_SEQ_TIMEOUT_EN
            tmo_q   <= 1'b0;
            block_q <= block_q & REQ;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state_q <= ST_PRE;
                        win_q   <= arb_win;
                        cnt_q   <= PRE_LD;
                        pause_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (!REQ[win_q]) begin
                        state_q <= ST_POST;
                        cnt_q   <= POST_LD;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= win_onehot;
`ifdef PAUSE_SEQ_TIMEOUT_EN
                        cnt_q   <= TMO_LD;
`endif
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_GRANT: begin
                    if (!REQ[win_q]) begin
                        state_q <= ST_POST;
                        gnt_q   <= '0;
                        cnt_q   <= POST_LD;
`ifdef PAUSE_SEQ_TIMEOUT_EN
                    end else if (cnt_q == '0) begin
                        state_q <= ST_POST;
                        gnt_q   <= '0;
                        cnt_q   <= POST_LD;
                        tmo_q   <= 1'b1;
                        block_q <= (block_q & REQ) | win_onehot;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
`endif
                    end
                end
                ST_POST: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_GAP;
                        cnt_q   <= GAP_LD;
                        pause_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    pause_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT             = gnt_q;
    assign HS_IO_CLK_PAUSE = pause_q;
    assign BUSY            = busy_q;

endmodule

// File: tb/tb_lanectrl_pause_sequencer.sv
// Bench for lanectrl_pause_sequencer. A window-level model predicts, for every
// arbitration, the winner and the cycles at which pause/GNT/BUSY edges occur;
// a negedge monitor pops those predictions as the DUT opens windows.
module tb_lanectrl_pause_sequencer;

    localparam int N    = 4;
    localparam int PRE  = 4;
    localparam int POST = 4;
    localparam int GAP  = 2;
`ifdef PAUSE_SEQ_TIMEOUT_EN
    localparam int TMO     = 16;
    localparam bit USE_TMO = 1'b1;
`else
    localparam int TMO     = 256;
    localparam bit USE_TMO = 1'b0;
`endif

    logic         CLK   = 1'b0;
    logic         RESET = 1'b1;
    logic [N-1:0] REQ   = '0;
    logic [N-1:0] GNT;
    logic         PAUSE;
    logic         BUSY;
    logic         TERR;

    lanectrl_pause_sequencer #(
        .NUM_REQ        (N),
        .PRE_CYCLES     (PRE),
        .POST_CYCLES    (POST),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .REQ             (REQ),
        .GNT             (GNT),
        .HS_IO_CLK_PAUSE (PAUSE),
        .BUSY            (BUSY),
        .TIMEOUT_ERR     (TERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int w;
        int pause_rise;
        int gnt_rise;
        int gnt_fall;
        int pause_fall;
        int idle;
        bit aborted;
        bit timed_out;
    } win_t;

    win_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   cyc      = 0;

    // requester agents
    logic [N-1:0] req_drv = '0;
    int   hold[N];
    int   gcnt[N];
    int   stuck[N];
    int   abort_at[N];
    int   raise_at[N];
    bit   auto_en = 1'b0;

    // window-level model
    int           m_idle = 0;
    int           m_ptr  = 0;
    logic [N-1:0] m_blk  = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Called with the REQ vector present during cycle c (sampled at its end).
    task automatic model_step(input int c, input logic [N-1:0] req);
        logic [N-1:0] pend;
        win_t r;
        int   w;
        int   idx;
        pend  = req & ~m_blk;
        m_blk = m_blk & req;
        if (c >= m_idle && pend != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && pend[idx]) w = idx;
            end
            r = '{default: 0};
            r.w          = w;
            r.pause_rise = c + 1;
            r.gnt_rise   = c + 1 + PRE;
            if (abort_at[w] >= 0) begin
                r.aborted    = 1'b1;
                r.pause_fall = abort_at[w] + 1 + POST;
            end else begin
                if (USE_TMO && hold[w] > TMO) begin
                    r.timed_out = 1'b1;
                    r.gnt_fall  = r.gnt_rise + TMO;
                    m_blk[w]    = 1'b1;
                end else begin
                    r.gnt_fall = r.gnt_rise + hold[w];
                end
                r.pause_fall = r.gnt_fall + POST;
            end
            r.idle = r.pause_fall + GAP;
            m_idle = r.idle;
            m_ptr  = (w + 1) % N;
            exp_q.push_back(r);
            pushed++;
        end
    endtask

    task automatic req_raise(input int i, input int h, input int ab);
        req_drv[i] = 1'b1;
        hold[i]    = h;
        gcnt[i]    = 0;
        stuck[i]   = $urandom_range(0, 20);
        abort_at[i] = ab;
        REQ = req_drv;
    endtask

    task automatic req_drop(input int i);
        req_drv[i]  = 1'b0;
        gcnt[i]     = 0;
        abort_at[i] = -1;
        raise_at[i] = cyc + $urandom_range(1, 12);
    endtask

    function automatic int rand_hold();
        if (USE_TMO && $urandom_range(0, 5) == 0) return $urandom_range(TMO + 1, TMO + 8);
        return $urandom_range(1, 8);
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (req_drv[i]) begin
                if (abort_at[i] >= 0) begin
                    if (cyc >= abort_at[i]) req_drop(i);
                end else if (GNT[i]) begin
                    gcnt[i]++;
                    if (gcnt[i] >= hold[i]) req_drop(i);
                end else if (gcnt[i] > 0) begin
                    // grant was cut short: stay stuck high a while, then drop
                    if (stuck[i] == 0) req_drop(i);
                    else stuck[i]--;
                end
            end else if (auto_en && cyc >= raise_at[i]) begin
                req_raise(i, rand_hold(), -1);
            end
        end
        REQ = req_drv;
    endtask

    task automatic step();
        @(posedge CLK);
        if (!RESET) model_step(cyc, req_drv);
        cyc++;
        #1;
        if (!RESET) drive_reqs();
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (k < limit && !(req_drv == '0 && exp_q.size() == 0 && cyc > m_idle + 1)) begin
            step();
            k++;
        end
        chk("drain_done", int'(k < limit), 1);
        chk("idle_after_drain", int'(BUSY), 0);
    endtask

    // monitor
    win_t         cur;
    bit           have_cur = 1'b0;
    bit           seen_win = 1'b0;
    logic         pp = 1'b0;
    logic         bp = 1'b0;
    logic [N-1:0] gp = '0;
    int           low_run  = 0;
    int           high_run = 0;

    always @(negedge CLK) begin
        if (RESET) begin
            pp = 1'b0; bp = 1'b0; gp = '0;
            have_cur = 1'b0; seen_win = 1'b0;
            low_run = 0; high_run = 0;
        end else begin
            if (GNT != '0) begin
                chk("gnt_inside_pause", int'(PAUSE), 1);
                chk("gnt_onehot", $countones(GNT), 1);
            end
            if (PAUSE && !pp) begin
                if (exp_q.size() == 0) begin
                    chk("window_expected", 0, 1);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    popped++;
                    chk("pause_rise_cycle", cyc, cur.pause_rise);
                    if (seen_win) chk("pause_low_min", int'(low_run >= GAP + 1), 1);
                end
                seen_win = 1'b1;
            end
            if (GNT != '0 && gp == '0) begin
                if (!have_cur || cur.aborted) begin
                    chk("gnt_expected", 0, 1);
                end else begin
                    chk("gnt_value", int'(GNT), 1 << cur.w);
                    chk("gnt_rise_cycle", cyc, cur.gnt_rise);
                end
            end
            if (GNT == '0 && gp != '0 && have_cur) chk("gnt_fall_cycle", cyc, cur.gnt_fall);
            if (!PAUSE && pp && have_cur) begin
                chk("pause_fall_cycle", cyc, cur.pause_fall);
                chk("pause_high_min", int'(high_run >= POST + 1), 1);
            end
            if (BUSY && !bp) chk("busy_with_pause", int'(PAUSE), 1);
            if (!BUSY && bp && have_cur) chk("idle_cycle", cyc, cur.idle);
            chk("timeout_err", int'(TERR),
                int'(have_cur && cur.timed_out && cyc == cur.gnt_fall));
            if (PAUSE) begin high_run++; low_run = 0; end
            else begin low_run++; high_run = 0; end
            pp = PAUSE; bp = BUSY; gp = GNT;
        end
    end

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            hold[i] = 1; gcnt[i] = 0; stuck[i] = 0; abort_at[i] = -1; raise_at[i] = 0;
        end

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_gnt", int'(GNT), 0);
        chk("reset_pause", int'(PAUSE), 0);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_terr", int'(TERR), 0);
        RESET = 1'b0;
        repeat (5) step();

        // single requester, long grant
        req_raise(0, 16, -1);
        drain(200);

        // abort during PRE; pointer must move past 2
        req_raise(2, 1, cyc + 2);
        drain(100);

        // all requesters at once, served in pointer order
        for (int i = 0; i < N; i++) req_raise(i, 3, -1);
        drain(300);

`ifdef PAUSE_SEQ_TIMEOUT_EN
        // stuck requester hits the grant limit
        req_raise(1, TMO + 30, -1);
        req_raise(3, 2, -1);
        drain(400);
`endif

        // randomized traffic
        auto_en = 1'b1;
        for (int i = 0; i < N; i++) raise_at[i] = cyc + $urandom_range(0, 10);
        repeat (3000) step();
        auto_en = 1'b0;
        drain(3000);

        // reset in the middle of a grant
        req_raise(0, 40, -1);
        k = 0;
        while (GNT == '0 && k < 50) begin
            step();
            k++;
        end
        chk("gnt_before_reset", int'(GNT != '0), 1);
        repeat (3) step();
        #2;
        RESET = 1'b1;
        #1;
        chk("async_reset_gnt", int'(GNT), 0);
        chk("async_reset_pause", int'(PAUSE), 0);
        chk("async_reset_busy", int'(BUSY), 0);
        exp_q.delete();
        m_idle = 0;
        m_ptr  = 0;
        m_blk  = '0;
        req_drv = '0;
        REQ = '0;
        for (int i = 0; i < N; i++) begin
            gcnt[i] = 0; abort_at[i] = -1;
        end
        step();
        step();
        RESET = 1'b0;
        step();
        req_raise(1, 5, -1);
        drain(100);

        chk("queue_empty", exp_q.size(), 0);
        chk("windows_seen", popped, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
